// File: rtl/tilexy_cl_ack_pkg.sv
// Shared types for the cache-line write ack responder: entry layouts, ack packet
// field positions, drain FSM states and the ack port routing rule.
package tilexy_cl_ack_pkg;

    localparam int COORD_W = 5;
    localparam int DATA_W  = 528;
    localparam int ADDR_W  = 37;
    localparam int SIZE_W  = 12;
    localparam int MSK_W   = 10;
    localparam int TAG_W   = 27;

    // Ack packet bit positions; ACKPKT_SIZE is the MSB index of the packet.
    localparam int ACKPKT_SND   = 0;
    localparam int ACKPKT_TX    = 1;
    localparam int ACKPKT_TY    = 6;
    localparam int ACKPKT_TAG   = 11;
    localparam int ACKPKT_FLUSH = 38;
    localparam int ACKPKT_SIZE  = 38;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [ADDR_W-1:0]  addr;
        logic [MSK_W-1:0]   msk;
        logic [COORD_W-1:0] src_ty;
        logic [COORD_W-1:0] src_tx;
    } req_ent_t;

    // Queued ack: the packet minus the snd bit, which is implied by a launch.
    typedef struct packed {
        logic               flush;
        logic [TAG_W-1:0]   tag;
        logic [COORD_W-1:0] ty;
        logic [COORD_W-1:0] tx;
    } ack_ent_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} drain_st_t;

    // Returns the output port: 0 (back) when the source is at or below us, else 1.
    function automatic logic route_back(input logic [COORD_W-1:0] c, input logic [COORD_W-1:0] t);
        return c > t;
    endfunction

endpackage

// File: rtl/tilexy_cl_ack_if.sv
// Request, line-store and ack-link signals of the ack responder, bundled as one bus.
interface tilexy_cl_ack_if;
    import tilexy_cl_ack_pkg::*;

    logic                         req_en;
    logic [DATA_W-1:0]            req_data;
    logic [ADDR_W-1:0]            req_addr;
    logic [SIZE_W-1:0]            req_size;
    logic [COORD_W-1:0]           req_src_tx;
    logic [COORD_W-1:0]           req_src_ty;
    logic                         req_stall;
    logic                         err_ovf;
    logic                         mem_wr_en;
    logic [ADDR_W-1:0]            mem_wr_addr;
    logic [DATA_W-1:0]            mem_wr_data;
    logic [MSK_W-1:0]             mem_wr_msk;
    logic                         mem_wr_ack;
    logic [1:0][ACKPKT_SIZE:0]    ack_out;
    logic [1:0]                   ack_crd_in;

    modport slave (
        input  req_en, req_data, req_addr, req_size, req_src_tx, req_src_ty,
        input  mem_wr_ack, ack_crd_in,
        output req_stall, err_ovf, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_msk, ack_out
    );

    modport master (
        output req_en, req_data, req_addr, req_size, req_src_tx, req_src_ty,
        output mem_wr_ack, ack_crd_in,
        input  req_stall, err_ovf, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_msk, ack_out
    );

endinterface

// File: rtl/tilexy_cl_ack_ring_fifo.sv
// Circular buffer with wrap-bit pointers; the caller must not push when full
// unless it pops in the same cycle (the slot being vacated is then reused).
module tilexy_cl_ack_ring_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0]  mem_q [DEPTH];

    always_comb begin
        wr_d = wr_q + PW'(push);
        rd_d = rd_q + PW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= din;
    end

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/tilexy_cl_ack.sv
// Destination-tile responder: buffers delivered line writes, drains them into the
// line store and returns one credit-flow-controlled ack per request toward its source.
module tilexy_cl_ack
    import tilexy_cl_ack_pkg::*;
#(
    parameter int tile_X = 0,
    parameter int tile_Y = 0,
    parameter int IDX    = 0,
    parameter int DEPTH  = 8,
    parameter int ACKQ   = 4
) (
    input logic            clk,
    input logic            rst,
    tilexy_cl_ack_if.slave bus
);
    localparam int CW  = $clog2(ACKQ + 1);
    localparam int CSW = CW + 1;
    localparam logic [CW-1:0]      CRD_MAX = CW'(ACKQ);
    localparam logic [COORD_W-1:0] MY_C    = COORD_W'((IDX < 2) ? tile_X : tile_Y);

    req_ent_t                  rq_in, rq_head;
    logic                      rq_push, rq_pop, rq_full, rq_empty;
    ack_ent_t                  aq_in, aq_head;
    logic                      aq_push, aq_pop, aq_full, aq_empty;
    drain_st_t                 state_q, state_d;
    logic                      err_ovf_q, err_ovf_d;
    logic [1:0][CW-1:0]        crd_q, crd_d;
    logic [1:0][CSW-1:0]       crd_sum;
    logic [1:0][ACKPKT_SIZE:0] ack_out_q, ack_out_d;
    logic                      mem_wr_en, flush_only, aq_port, send;

    assign rq_in = '{data:   bus.req_data,
                     addr:   bus.req_addr,
                     msk:    bus.req_size[MSK_W-1:0],
                     src_ty: bus.req_src_ty,
                     src_tx: bus.req_src_tx};

    // A full buffer still takes a request in the cycle its head retires.
    assign rq_pop    = (state_q == S_ACK);
    assign rq_push   = bus.req_en && (!rq_full || rq_pop);
    assign err_ovf_d = err_ovf_q || (bus.req_en && rq_full && !rq_pop);

    tilexy_cl_ack_ring_fifo #(.W($bits(req_ent_t)), .DEPTH(DEPTH)) u_req_q (
        .clk(clk), .rst(rst), .push(rq_push), .pop(rq_pop), .din(rq_in),
        .full(rq_full), .empty(rq_empty), .head(rq_head)
    );

    assign flush_only = (rq_head.msk == '0);
    assign aq_in = '{flush: flush_only,
                     tag:   rq_head.addr[TAG_W-1:0],
                     ty:    rq_head.src_ty,
                     tx:    rq_head.src_tx};

    always_comb begin
        state_d   = state_q;
        mem_wr_en = 1'b0;
        aq_push   = 1'b0;
        unique case (state_q)
            // Only ACK pushes acks, so checking for room here is enough.
            S_IDLE:  if (!rq_empty && !aq_full) state_d = S_ISSUE;
            S_ISSUE: begin
                if (flush_only) begin
                    state_d = S_ACK;
                end else begin
                    mem_wr_en = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                mem_wr_en = 1'b1;
                if (bus.mem_wr_ack) state_d = S_ACK;
            end
            S_ACK: begin
                aq_push = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    tilexy_cl_ack_ring_fifo #(.W($bits(ack_ent_t)), .DEPTH(ACKQ)) u_ack_q (
        .clk(clk), .rst(rst), .push(aq_push), .pop(aq_pop), .din(aq_in),
        .full(aq_full), .empty(aq_empty), .head(aq_head)
    );

    // Strict FIFO: a credit-starved head blocks acks bound for the other port.
    assign aq_port = route_back((IDX < 2) ? aq_head.tx : aq_head.ty, MY_C);
    assign send    = !aq_empty && (crd_q[aq_port] != '0);
    assign aq_pop  = send;

    always_comb begin
        crd_sum   = '0;
        crd_d     = crd_q;
        ack_out_d = '0;
        if (send) ack_out_d[aq_port] = {aq_head, 1'b1};
        for (int p = 0; p < 2; p++) begin
            crd_sum[p] = {1'b0, crd_q[p]} + CSW'(bus.ack_crd_in[p])
                       - CSW'(send && (aq_port == 1'(p)));
            crd_d[p]   = (crd_sum[p] > {1'b0, CRD_MAX}) ? CRD_MAX : crd_sum[p][CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            err_ovf_q <= 1'b0;
            crd_q     <= {2{CRD_MAX}};
            ack_out_q <= '0;
        end else begin
            state_q   <= state_d;
            err_ovf_q <= err_ovf_d;
            crd_q     <= crd_d;
            ack_out_q <= ack_out_d;
        end
    end

    assign bus.req_stall   = rq_full;
    assign bus.err_ovf     = err_ovf_q;
    assign bus.mem_wr_en   = mem_wr_en;
    assign bus.mem_wr_addr = rq_head.addr;
    assign bus.mem_wr_data = rq_head.data;
    assign bus.mem_wr_msk  = rq_head.msk;
    assign bus.ack_out     = ack_out_q;

endmodule

// File: tb/tb_tilexy_cl_ack.sv
// Directed plus randomized bench for tilexy_cl_ack against an in-order request/ack model.
module tb_tilexy_cl_ack;
    localparam int TX = 3;
    localparam int TY = 2;
    localparam int ACKQ = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tilexy_cl_ack_if bus();

    tilexy_cl_ack #(.tile_X(TX), .tile_Y(TY), .IDX(0), .DEPTH(8), .ACKQ(ACKQ)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct { int port; logic [38:0] pkt; } exp_ack_t;
    typedef struct { logic [36:0] addr; logic [9:0] msk; logic [527:0] data; } exp_wr_t;

    exp_ack_t exp_q[$];
    exp_wr_t  wr_q[$];
    int ncmp = 0, nfail = 0;
    int seen[2], crd[2], owed[2];
    bit auto_ack, auto_crd;
    int ack_dly = 1, wcnt = 0;

    task automatic chk(input string tag, input logic [599:0] obs, input logic [599:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, then drive the next inputs.
    task automatic cyc();
        exp_ack_t e;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (bus.ack_out[p][0] === 1'b1) begin
                seen[p]++;
                owed[p]++;
                chk("ack_expected", 600'(exp_q.size() > 0), 600'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("ack_port", 600'(p), 600'(e.port));
                    chk("ack_pkt", 600'(bus.ack_out[p]), 600'(e.pkt));
                    chk("ack_credit", 600'(crd[p] > 0), 600'(1));
                    crd[p]--;
                end
            end
        end
        if (bus.mem_wr_en === 1'b1) begin
            chk("wr_expected", 600'(wr_q.size() > 0), 600'(1));
            if (wr_q.size() > 0)
                chk("wr_fields", 600'({bus.mem_wr_addr, bus.mem_wr_msk, bus.mem_wr_data}),
                    600'({wr_q[0].addr, wr_q[0].msk, wr_q[0].data}));
            wcnt++;
        end else begin
            wcnt = 0;
        end
        bus.mem_wr_ack = 1'b0;
        if (auto_ack && wcnt > ack_dly) begin
            bus.mem_wr_ack = 1'b1;
            wcnt = 0;
            if (wr_q.size() > 0) void'(wr_q.pop_front());
        end
        bus.ack_crd_in = 2'b00;
        if (auto_crd) begin
            for (int p = 0; p < 2; p++) begin
                if (owed[p] > 0 && $urandom_range(0, 2) == 0) begin
                    bus.ack_crd_in[p] = 1'b1;
                    owed[p]--;
                    crd[p]++;
                end
            end
        end
    endtask

    task automatic push_req(input logic [4:0] tx, input logic [4:0] ty, input logic [9:0] msk,
                            input bit accept);
        logic [36:0]  addr;
        logic [527:0] data;
        exp_ack_t     e;
        exp_wr_t      w;
        addr = 37'({$urandom(), $urandom()});
        for (int i = 0; i < 16; i++) data[i*32 +: 32] = $urandom();
        data[527:512] = 16'($urandom());
        bus.req_en     = 1'b1;
        bus.req_data   = data;
        bus.req_addr   = addr;
        bus.req_size   = {2'($urandom_range(0, 3)), msk};
        bus.req_src_tx = tx;
        bus.req_src_ty = ty;
        if (accept) begin
            e.port = (int'(tx) > TX) ? 1 : 0;
            e.pkt  = {msk == 10'd0, addr[26:0], ty, tx, 1'b1};
            exp_q.push_back(e);
            if (msk != 10'd0) begin
                w.addr = addr; w.msk = msk; w.data = data;
                wr_q.push_back(w);
            end
        end
        cyc();
        bus.req_en = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || wr_q.size() > 0) && n < budget) begin
            cyc();
            n++;
        end
        repeat (6) cyc();
        chk(tag, 600'(exp_q.size() + wr_q.size()), 600'(0));
    endtask

    // Five acks toward port1 with no credit returns: four leave, the fifth needs a credit.
    task automatic credit_block(input string pfx);
        int s1 = seen[1];
        int n = 0;
        for (int i = 0; i < 5; i++)
            push_req(5'd7, 5'($urandom_range(0, 31)),
                     (i % 2 == 1) ? 10'd0 : 10'($urandom_range(1, 1023)), 1'b1);
        while (exp_q.size() > 1 && n < 80) begin
            cyc();
            n++;
        end
        repeat (6) cyc();
        chk({pfx, "_four_sent"}, 600'(seen[1] - s1), 600'(4));
        chk({pfx, "_fifth_held"}, 600'(exp_q.size()), 600'(1));
        bus.ack_crd_in = 2'b10;
        crd[1]++;
        owed[1]--;
        cyc();
        chk({pfx, "_not_yet"}, 600'(seen[1] - s1), 600'(4));
        cyc();
        chk({pfx, "_fifth_sent"}, 600'(seen[1] - s1), 600'(5));
    endtask

    initial begin
        int s0, g;
        rst = 1'b0;
        bus.req_en = 1'b0; bus.req_data = '0; bus.req_addr = '0; bus.req_size = '0;
        bus.req_src_tx = '0; bus.req_src_ty = '0; bus.mem_wr_ack = 1'b0; bus.ack_crd_in = 2'b00;
        for (int p = 0; p < 2; p++) begin seen[p] = 0; crd[p] = ACKQ; owed[p] = 0; end
        auto_ack = 1'b1; auto_crd = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_stall", 600'(bus.req_stall), 600'(0));
        chk("rst_ovf", 600'(bus.err_ovf), 600'(0));
        chk("rst_wr_en", 600'(bus.mem_wr_en), 600'(0));
        chk("rst_ack_out", 600'(bus.ack_out), 600'(0));
        rst = 1'b1;
        cyc();

        // Single write: mem_wr_en two cycles after req_en, ack back on port0.
        ack_dly = 2;
        s0 = seen[0];
        push_req(5'd1, 5'd2, 10'h3FF, 1'b1);
        chk("t1_wr_en_n1", 600'(bus.mem_wr_en), 600'(0));
        cyc();
        chk("t1_wr_en_n2", 600'(bus.mem_wr_en), 600'(1));
        g = 0;
        while (seen[0] == s0 && g < 12) begin cyc(); g++; end
        chk("t1_ack_port0", 600'(seen[0] - s0), 600'(1));

        // Flush-only: ISSUE at N+2, ack_out three cycles later.
        push_req(5'd1, 5'd2, 10'h000, 1'b1);
        repeat (3) cyc();
        chk("t2_ack_early", 600'(bus.ack_out[0][0]), 600'(0));
        cyc();
        chk("t2_ack_flush_time", 600'(bus.ack_out[0][0]), 600'(1));

        // Fill with writes held, overflow once, then push while the head retires.
        auto_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_req(5'd1, 5'd2, 10'($urandom_range(1, 1023)), 1'b1);
            if (i == 6) chk("t3_stall_at7", 600'(bus.req_stall), 600'(0));
        end
        chk("t3_stall_at8", 600'(bus.req_stall), 600'(1));
        push_req(5'd9, 5'd9, 10'h3FF, 1'b0);
        chk("t3_ovf", 600'(bus.err_ovf), 600'(1));
        chk("t3_stall_held", 600'(bus.req_stall), 600'(1));
        chk("t5_in_wait", 600'(bus.mem_wr_en), 600'(1));
        bus.mem_wr_ack = 1'b1;
        if (wr_q.size() > 0) void'(wr_q.pop_front());
        cyc();
        push_req(5'd2, 5'd1, 10'h155, 1'b1);
        chk("t5_full_kept", 600'(bus.req_stall), 600'(1));
        auto_ack = 1'b1; ack_dly = 1;
        wait_drain("t35_drain", 400);

        // Port1 credit exhaustion and single credit return.
        auto_crd = 1'b0;
        repeat (4) cyc();
        credit_block("t4");

        // Asynchronous reset while a write waits; credits come back full.
        auto_ack = 1'b0;
        for (int i = 0; i < 8; i++) push_req(5'd0, 5'd0, 10'($urandom_range(1, 1023)), 1'b1);
        chk("t6_full", 600'(bus.req_stall), 600'(1));
        chk("t6_in_wait", 600'(bus.mem_wr_en), 600'(1));
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_wr_en", 600'(bus.mem_wr_en), 600'(0));
        chk("t6_rst_stall", 600'(bus.req_stall), 600'(0));
        exp_q.delete(); wr_q.delete(); wcnt = 0;
        for (int p = 0; p < 2; p++) begin crd[p] = ACKQ; owed[p] = 0; end
        cyc();
        rst = 1'b1;
        auto_ack = 1'b1;
        credit_block("t6");
        auto_crd = 1'b1;

        // Randomized traffic under flow control.
        for (int i = 0; i < 60; i++) begin
            g = 0;
            while (bus.req_stall === 1'b1 && g < 50) begin cyc(); g++; end
            ack_dly = $urandom_range(1, 3);
            push_req(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023)), 1'b1);
            repeat ($urandom_range(0, 2)) cyc();
        end
        wait_drain("rand_drain", 2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
